// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: decides branch/jump direction, detects mispredicts, issues a
// registered flush/redirect and maintains the 2-bit saturating branch history table.
module branch_resolve_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BHT_IDX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] if_pc_i,
  output logic             if_pred_taken_o,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_is_jump_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [WIDTH-1:0] ex_pc_i,
  input  logic             ex_pred_taken_i,
  input  logic [WIDTH-1:0] ex_pred_target_i,
  input  logic [WIDTH-1:0] ex_target_i,
  input  logic             z_flag_i,
  input  logic             o_flag_i,
  output logic             flush_o,
  output logic [WIDTH-1:0] redirect_pc_o,
  output logic [15:0]      mispredict_cnt_o
);

  localparam int unsigned BhtEntries = 2 ** BHT_IDX;

  logic [1:0]         bht_q [BhtEntries];
  logic [1:0]         bht_d [BhtEntries];
  logic               flush_q, flush_d;
  logic [WIDTH-1:0]   redirect_q, redirect_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [BHT_IDX-1:0] if_idx, ex_idx;
  logic               act;
  logic               br_taken, br_legal;
  logic               taken, tgt_mismatch, mispredict, bht_upd;
  logic               unused_pc_bits;

  assign if_idx          = if_pc_i[BHT_IDX+1:2];
  assign ex_idx          = ex_pc_i[BHT_IDX+1:2];
  assign if_pred_taken_o = bht_q[if_idx][1];
  assign unused_pc_bits  = ^{if_pc_i[WIDTH-1:BHT_IDX+2], if_pc_i[1:0]};

  // Wrong-path instruction sitting in EX during a flush cycle is ignored entirely.
  assign act = ex_valid_i & ~flush_q;

  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (ex_funct3_i)
      3'b000:          br_taken = z_flag_i;
      3'b001:          br_taken = ~z_flag_i;
      3'b100, 3'b110:  br_taken = o_flag_i;
      3'b101, 3'b111:  br_taken = ~o_flag_i;
      default:         br_legal = 1'b0;
    endcase
  end

  always_comb begin
    taken        = ex_is_jump_i | (ex_is_branch_i & br_taken);
    tgt_mismatch = (ex_pred_target_i != ex_target_i);
    mispredict   = 1'b0;
    if (act) begin
      if (ex_is_jump_i) begin
        mispredict = ~ex_pred_taken_i | tgt_mismatch;
      end else if (ex_is_branch_i) begin
        mispredict = (br_taken != ex_pred_taken_i) |
                     (br_taken & ex_pred_taken_i & tgt_mismatch);
      end
    end
    bht_upd = act & ex_is_branch_i & ~ex_is_jump_i & br_legal;
  end

  always_comb begin
    flush_d    = mispredict;
    redirect_d = redirect_q;
    cnt_d      = cnt_q;
    if (mispredict) begin
      redirect_d = taken ? ex_target_i : ex_pc_i + WIDTH'(4);
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (bht_upd) begin
      if (br_taken && bht_q[ex_idx] != 2'b11) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!br_taken && bht_q[ex_idx] != 2'b00) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < BhtEntries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
      bht_q      <= bht_d;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_pc_o    = redirect_q;
  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected flush events,
// a negedge monitor pops and compares them whenever the DUT raises flush.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_pred_target, ex_target;
  logic        ex_pred_taken, z_flag, o_flag;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  typedef struct {
    int          cyc;
    logic [31:0] rpc;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_resolve_unit #(.WIDTH(32), .BHT_IDX(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_pc_i          (if_pc),
    .if_pred_taken_o  (if_pred_taken),
    .ex_valid_i       (ex_valid),
    .ex_is_branch_i   (ex_is_branch),
    .ex_is_jump_i     (ex_is_jump),
    .ex_funct3_i      (ex_funct3),
    .ex_pc_i          (ex_pc),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .ex_target_i      (ex_target),
    .z_flag_i         (z_flag),
    .o_flag_i         (o_flag),
    .flush_o          (flush),
    .redirect_pc_o    (redirect_pc),
    .mispredict_cnt_o (mispredict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every flush pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (flush === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_flush: got redirect %h cnt %0d expected no flush (cycle %0d)",
                 redirect_pc, mispredict_cnt, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("flush_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("redirect_pc", redirect_pc, mon_e.rpc);
        chk("mispredict_cnt", {16'h0, mispredict_cnt}, {16'h0, mon_e.cnt});
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jump   = 1'b0;
  endtask

  task automatic issue(input logic br, input logic jmp, input logic [2:0] f3,
                       input logic [31:0] pc, input logic pred, input logic [31:0] ptgt,
                       input logic [31:0] tgt, input logic z, input logic o,
                       input logic exp_flush, input logic [31:0] exp_rpc,
                       input logic [15:0] exp_cnt);
    @(negedge clk);
    ex_valid       = 1'b1;
    ex_is_branch   = br;
    ex_is_jump     = jmp;
    ex_funct3      = f3;
    ex_pc          = pc;
    if_pc          = pc;
    ex_pred_taken  = pred;
    ex_pred_target = ptgt;
    ex_target      = tgt;
    z_flag         = z;
    o_flag         = o;
    if (exp_flush) exp_q.push_back('{cyc + 1, exp_rpc, exp_cnt});
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    idle();
    if_pc = pc;
    #1;
    chk(name, {31'h0, if_pred_taken}, {31'h0, exp});
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_funct3 = '0; ex_pc = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; ex_target = '0;
    z_flag = 1'b0; o_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_flush", {31'h0, flush}, 32'h0);
    chk("reset_cnt", {16'h0, mispredict_cnt}, 32'h0);
    chk("reset_redirect", redirect_pc, 32'h0);
    for (int i = 0; i < 16; i++) chk_pred("reset_bht_sweep", 32'(i * 4), 1'b0);

    // beq taken, predicted not taken; lookup in the update cycle sees the old value.
    issue(1, 0, 3'b000, 32'h100, 0, 32'h0, 32'h80, 1, 0, 1, 32'h80, 16'd1);
    #1 chk("beq_same_cycle_lookup", {31'h0, if_pred_taken}, 32'h0);
    idle();
    idle();
    #1;
    chk("beq_flush_pulse_ends", {31'h0, flush}, 32'h0);
    chk("beq_cnt", {16'h0, mispredict_cnt}, 32'd1);
    chk_pred("beq_bht_weak_taken", 32'h100, 1'b1);

    // bgeu not taken (o=1) but predicted taken: redirect to pc+4; BHT[0] back to 01.
    issue(1, 0, 3'b111, 32'h200, 1, 32'h40, 32'h40, 0, 1, 1, 32'h204, 16'd2);
    idle();
    idle();
    #1 chk("bgeu_flush_ends", {31'h0, flush}, 32'h0);
    chk_pred("bgeu_bht_dec", 32'h200, 1'b0);

    // Correctly predicted bne x4 saturates at 11; two not-taken steps reach 01.
    for (int i = 0; i < 4; i++)
      issue(1, 0, 3'b001, 32'h104, 1, 32'h500, 32'h500, 0, 0, 0, 32'h0, 16'd0);
    chk_pred("bne_sat_pred", 32'h104, 1'b1);
    issue(1, 0, 3'b001, 32'h104, 0, 32'h500, 32'h500, 1, 0, 0, 32'h0, 16'd0);
    chk_pred("bne_after_one_nt", 32'h104, 1'b1);
    issue(1, 0, 3'b001, 32'h104, 0, 32'h500, 32'h500, 1, 0, 0, 32'h0, 16'd0);
    chk_pred("bne_after_two_nt", 32'h104, 1'b0);

    // Mispredict followed by a wrong-path mispredicting branch during the flush cycle.
    issue(1, 0, 3'b100, 32'h108, 0, 32'h0, 32'h600, 0, 1, 1, 32'h600, 16'd3);
    issue(1, 0, 3'b100, 32'h108, 0, 32'h0, 32'h600, 0, 1, 0, 32'h0, 16'd0);
    idle();
    #1;
    chk("b2b_single_pulse", {31'h0, flush}, 32'h0);
    chk("b2b_cnt", {16'h0, mispredict_cnt}, 32'd3);
    // One update took BHT[2] to 10; a not-taken step must bring it to 01.
    issue(1, 0, 3'b100, 32'h108, 0, 32'h0, 32'h600, 0, 0, 0, 32'h0, 16'd0);
    chk_pred("b2b_single_bht_update", 32'h108, 1'b0);

    // jal (branch flag also set) with wrong predicted target; reset lands in the flush cycle.
    issue(1, 1, 3'b000, 32'h10c, 1, 32'h300, 32'h304, 0, 0, 1, 32'h304, 16'd4);
    @(negedge clk);
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    rst = 1'b1;
    if_pc = 32'h10c;
    #1 chk("jal_bht_unchanged", {31'h0, if_pred_taken}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_flush", {31'h0, flush}, 32'h0);
    chk("rst_mid_cnt", {16'h0, mispredict_cnt}, 32'h0);
    chk("rst_mid_redirect", redirect_pc, 32'h0);

    // pc+4 wraps to zero.
    issue(1, 0, 3'b001, 32'hFFFF_FFFC, 1, 32'h10, 32'h10, 1, 0, 1, 32'h0, 16'd1);
    idle();
    // Reserved funct3: never taken, so a taken prediction mispredicts to pc+4.
    issue(1, 0, 3'b011, 32'h118, 1, 32'h700, 32'h700, 1, 1, 1, 32'h11c, 16'd2);
    idle();
    issue(1, 0, 3'b010, 32'h114, 0, 32'h0, 32'h0, 1, 1, 0, 32'h0, 16'd0);
    chk_pred("illegal_f3_no_update", 32'h114, 1'b0);

    repeat (3) idle();
    chk("pending_expected_flushes", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolver for the 4-stage pipeline. It sits directly downstream of the ALU and consumes its `z_flag`/`o_flag` for the branch instruction in EX. It decides the actual direction of every branch and jump, compares that decision against the fetch-time prediction, and issues a registered flush/redirect on a mispredict. It also owns the 2-bit saturating branch history table (BHT) that fetch reads for predictions.

## Interface
- `WIDTH`, 32, datapath/PC width
- `BHT_IDX`, 4, BHT index bits (2**BHT_IDX entries)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `if_pc` in WIDTH — fetch PC for prediction lookup
- `if_pred_taken` out 1 — combinational prediction for `if_pc`
- `ex_valid` in 1 — EX holds a real instruction
- `ex_is_branch` in 1 — EX instruction is a conditional branch
- `ex_is_jump` in 1 — EX instruction is jal/jalr
- `ex_funct3` in 3 — branch funct3
- `ex_pc` in WIDTH — PC of the EX instruction
- `ex_pred_taken` in 1 — prediction carried down from fetch
- `ex_pred_target` in WIDTH — target fetch used if predicted taken
- `ex_target` in WIDTH — computed branch/jump target
- `z_flag` in 1 — ALU zero flag (result of rs1−rs2)
- `o_flag` in 1 — ALU less-than flag (signed or unsigned per ALU control)
- `flush` out 1 — registered; squash IF/ID and the current EX instruction
- `redirect_pc` out WIDTH — registered; next fetch PC, valid when `flush`=1
- `mispredict_cnt` out 16 — saturating mispredict count

## Operation
- Reset: `flush`=0, `redirect_pc`=0, `mispredict_cnt`=0, all BHT entries=2'b01 (weakly not-taken).
- Effective instruction: `act = ex_valid & ~flush`. The instruction in EX during a flush cycle is wrong-path and is ignored completely: no BHT update, no flush, no count.
- Branch direction when `ex_is_branch`, by `ex_funct3`:
  - 000 beq → `z_flag`
  - 001 bne → `~z_flag`
  - 100 blt / 110 bltu → `o_flag`
  - 101 bge / 111 bgeu → `~o_flag`
  - 010/011 → not taken, no BHT update
- Decode sets the ALU to signed subtract for blt/bge and unsigned subtract for bltu/bgeu. This unit does not check that.
- Jumps are always taken. `ex_is_jump` has priority over `ex_is_branch` if both are set.
- Mispredict condition (when `act`):
  - Branch: `taken != ex_pred_taken`, or `taken & ex_pred_taken & (ex_pred_target != ex_target)`.
  - Jump: `~ex_pred_taken | (ex_pred_target != ex_target)`.
- On mispredict, at the next edge: `flush`←1, `redirect_pc`←(taken ? `ex_target` : `ex_pc`+4), `mispredict_cnt`←min(cnt+1, 16'hFFFF). Otherwise `flush`←0 and `redirect_pc` holds its value.
- `flush` is a one-cycle pulse per mispredict. Back-to-back pulses cannot occur because of the `act` gating.
- BHT index is `pc[BHT_IDX+1:2]`. `if_pred_taken` = bit 1 of `BHT[if_pc index]`.
- BHT update happens on the edge for an `act` conditional branch with legal funct3. Jumps do not update.
  - Taken: counter +1, saturating at 11.
  - Not taken: counter −1, saturating at 00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- PC+4 wraps modulo 2**WIDTH.

## Timing
- Resolution latency is 1 cycle: branch in EX at cycle N gives `flush`/`redirect_pc` valid during cycle N+1. Fetch uses `redirect_pc` at the N+1 edge.
- BHT lookup is combinational, with no bypass. A lookup and an update to the same index in the same cycle return the pre-update value. The new value is visible from the next cycle.
- `rst` asserted mid-operation wins over everything at that edge. A pending flush is dropped and outputs return to reset values.
- `mispredict_cnt` updates on the same edge that sets `flush`.

## Test plan
- Reset, then sweep `if_pc` over all 16 indices → `if_pred_taken`=0 everywhere; `flush`=0, `mispredict_cnt`=0.
- beq at `ex_pc`=0x100 with `z_flag`=1, `ex_pred_taken`=0, `ex_target`=0x80 → next cycle `flush`=1, `redirect_pc`=0x80, cnt=1; following cycle `flush`=0; `BHT[0]`=10 so `if_pc`=0x100 predicts taken.
- bgeu with `o_flag`=1, pred taken, target 0x40 at `ex_pc`=0x200 → `flush`=1, `redirect_pc`=0x204.
- Correctly predicted bne (`z_flag`=0, pred taken, `ex_pred_target`==`ex_target`) applied 4× at one PC → no flush; counter saturates at 11. Then 1× not taken → 10, still predicts taken.
- Mispredict at cycle N with `ex_valid`=1 mispredicting branch also in EX at N+1 → only one flush pulse, no second BHT update, cnt +1 only.
- jal pred taken, `ex_pred_target`=0x300, `ex_target`=0x304 → flush, `redirect_pc`=0x304, BHT unchanged. Assert `rst` in the flush cycle → next cycle `flush`=0, cnt=0.
